spi_master: RTL

//  SPI mode-3 master (CPOL=1, CPHA=1) for the SBC-side SPI link; counterpart of the gateware SPI slave.

---
 rtl/spi_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI mode-3 master (CPOL=1, CPHA=1): one WIDTH-bit full-duplex frame per accepted start.
// Latency: done pulses (2*WIDTH+2)*CLKDIV+1 clk cycles after the clk edge that samples start.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   clk, rstb      system clock; asynchronous active-low reset
//   start          frame request (sampled in IDLE only)
//   mlb            bit order, 1 = MSB first; latched together with tdata at start
//   tdata          word to transmit
//   busy           high from the cycle after start is accepted until the inter-frame gap ends
//   done           one-cycle pulse at frame end; rdata is valid in that cycle
//   rdata          received word, held until the next done
//   ss, sck, sdout SPI outputs (ss active-low, sck idles high, sdout always driven)
//   sdin           MISO
module spi_master #(
   parameter int WIDTH  = 48,
   parameter int CLKDIV = 4,
   parameter int CS_GAP = 2
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             start,
   input  logic             mlb,
   input  logic [WIDTH-1:0] tdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rdata,
   output logic             ss,
   output logic             sck,
   output logic             sdout,
   input  logic             sdin
);

   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

   state_t           state_q, state_d;
   logic [7:0]       hcnt_q, hcnt_d;
   logic [6:0]       bcnt_q, bcnt_d;
   logic [GW-1:0]    gcnt_q, gcnt_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             mlb_q, mlb_d;
   logic             ss_q, ss_d;
   logic             sck_q, sck_d;
   logic             sdout_q, sdout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             hend;
   logic             tx_bit;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-1:0] rx_shift;

   assign hend     = (hcnt_q == 8'(CLKDIV - 1));
   assign tx_bit   = mlb_q ? tx_q[WIDTH-1] : tx_q[0];
   assign tx_shift = mlb_q ? {tx_q[WIDTH-2:0], 1'b1} : {1'b1, tx_q[WIDTH-1:1]};
   assign rx_shift = mlb_q ? {rx_q[WIDTH-2:0], sdin} : {sdin, rx_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q + 8'd1;
      bcnt_d  = bcnt_q;
      gcnt_d  = gcnt_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      mlb_d   = mlb_q;
      ss_d    = ss_q;
      sck_d   = sck_q;
      sdout_d = sdout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            hcnt_d = '0;
            if (start) begin
               tx_d    = tdata;
               mlb_d   = mlb;
               state_d = SETUP;
            end
         end
         // The first SETUP cycle is the acceptance cycle where ss/busy go active,
         // so hcnt runs to CLKDIV here to leave a full half-period of ss-low setup.
         SETUP: begin
            ss_d   = 1'b0;
            busy_d = 1'b1;
            if (hcnt_q == 8'(CLKDIV)) begin
               hcnt_d  = '0;
               bcnt_d  = '0;
               sck_d   = 1'b0;
               sdout_d = tx_bit;
               tx_d    = tx_shift;
               state_d = XFER;
            end
         end
         XFER: begin
            if (hend) begin
               hcnt_d = '0;
               if (!sck_q) begin
                  sck_d  = 1'b1;
                  rx_d   = rx_shift;
                  bcnt_d = bcnt_q + 7'd1;
               end else if (bcnt_q == 7'(WIDTH)) begin
                  // last high half-period complete; no further falling edge
                  state_d = HOLD;
               end else begin
                  sck_d   = 1'b0;
                  sdout_d = tx_bit;
                  tx_d    = tx_shift;
               end
            end
         end
         HOLD: begin
            if (hend) begin
               hcnt_d  = '0;
               gcnt_d  = '0;
               ss_d    = 1'b1;
               sdout_d = 1'b1;
               rdata_d = rx_q;
               done_d  = 1'b1;
               state_d = GAP;
            end
         end
         GAP: begin
            if (hend) begin
               hcnt_d = '0;
               gcnt_d = gcnt_q + 1'b1;
               if (gcnt_q == GW'(CS_GAP - 1)) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         hcnt_q  <= '0;
         bcnt_q  <= '0;
         gcnt_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         mlb_q   <= 1'b1;
         ss_q    <= 1'b1;
         sck_q   <= 1'b1;
         sdout_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         bcnt_q  <= bcnt_d;
         gcnt_q  <= gcnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         mlb_q   <= mlb_d;
         ss_q    <= ss_d;
         sck_q   <= sck_d;
         sdout_q <= sdout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign ss    = ss_q;
   assign sck   = sck_q;
   assign sdout = sdout_q;

endmodule
